audiomini_onchip_memory_arbiter: RTL and testbench
==================================================

Name: audiomini_onchip_memory_arbiter

Overview:
- Two-port Avalon-MM arbiter in front of the single-port 8192x64 on-chip RAM (13-bit word address, 8-bit byteenable, 1-cycle read latency) in audiomini_system.
- Shares the RAM between the HPS bridge (m0) and the audio datapath DMA (m1).
- Arbitrates round-robin every cycle and returns read data tagged to the correct requester.
- Presents standard waitrequest/readdatavalid slave interfaces upstream.

Parameters:
- ADDR_WIDTH, 13, word address width.
- DATA_WIDTH, 64, data width.
- BE_WIDTH, 8, byteenable width (DATA_WIDTH/8).
- READ_LATENCY, 1, memory read latency in cycles, from address-accept to readdata.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- mN_address  in  ADDR_WIDTH  requester N word address (N = 0, 1)
- mN_byteenable  in  BE_WIDTH  requester N byte enables
- mN_read  in  1  requester N read request
- mN_write  in  1  requester N write request
- mN_writedata  in  DATA_WIDTH  requester N write data
- mN_waitrequest  out  1  high = requester N command not accepted this cycle
- mN_readdata  out  DATA_WIDTH  requester N read data
- mN_readdatavalid  out  1  requester N read data valid
- mem_address  out  ADDR_WIDTH  to RAM address
- mem_byteenable  out  BE_WIDTH  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_WIDTH  to RAM writedata
- mem_clken  out  1  to RAM clken (constant 1)
- mem_readdata  in  DATA_WIDTH  from RAM

Behaviour:
- Request: reqN = mN_read | mN_write. If both are high from one requester, the write wins and the read is dropped; the bench flags this as a protocol error.
- Grant, combinational from reqN and the last_grant register:
  - One requester active: that requester is granted.
  - Both active: grant the requester that is not last_grant.
  - Neither active: no grant, mem_chipselect = 0.
- Waitrequest: mN_waitrequest = reset | (reqN & ~grantN). A granted command is accepted in the same cycle; the requester holds its command stable while waitrequest is high.
- Memory drive: mem_* mux the granted requester's fields. mem_write = granted write. mem_chipselect = any grant. With no grant, mem_address and mem_writedata hold the m0 fields (don't care).
- last_grant: updates on every accepted command to the granted id. Reset value is 1, so m0 wins the first contention.
- Read return pipeline: READ_LATENCY-deep shift register of {valid, id}; an entry is pushed for each accepted read.
  - mN_readdatavalid = pipe_out.valid & (pipe_out.id == N).
  - mN_readdata = mem_readdata for both ports; it is qualified only by that port's valid.
- Throughput and latency:
  - One command accepted per cycle; back-to-back reads are fully pipelined.
  - Read latency seen by a requester = READ_LATENCY cycles after acceptance.
  - Writes produce no response.
- Reset values: last_grant = 1, pipeline valids = 0, mN_readdatavalid = 0, mN_waitrequest = 1 while reset is high.
- Reset mid-read: in-flight pipeline entries are discarded (no readdatavalid after reset asserts); the requester must reissue.
- Sustained contention: strict alternation m0, m1, m0, ... Maximum wait for either requester is 1 cycle, so no starvation.
- Same-address write then read (either requester, consecutive cycles): the read returns the new data, because the RAM write completes before the next-cycle read.

Decomposition:
- Package audiomini_mem_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH and BE_WIDTH constants.
  - typedef req_id_t (1 bit).
  - struct rd_tag_t {valid, id}.
- One natural sub-module, audiomini_rd_tag_pipe: a parameterised READ_LATENCY shift register of rd_tag_t with async reset.
- The arbiter/mux stays in the top.

Test Plan:
- Reset, then m0 writes 0x0123456789ABCDEF to address 0x0005 with be=0xFF, then m0 reads 0x0005 -> m0_waitrequest=0 on both commands; m0_readdatavalid one cycle after the read with data 0x0123456789ABCDEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously from cycle 0 (m0 addr 0x0010, m1 addr 0x0020) -> grants alternate m0, m1, m0; each waitrequest is high on alternate cycles; each readdatavalid carries its own address's data, never swapped.
- Byte-lane write: m1 writes 0xFFFFFFFFFFFFFFFF with be=0x0F to address 0x1FFF (top word), previously 0 -> m1 read of 0x1FFF returns 0x00000000FFFFFFFF.
- Simultaneous m0 write (addr 0x0100, data 0xAA..AA) and m1 read (addr 0x0100), with last_grant=1 -> m0 is granted first; m1 is accepted the next cycle and returns 0xAA..AA.
- Assert reset one cycle after an accepted m1 read -> no readdatavalid on either port; both waitrequests are high during reset; after release, the first contention grants m0.
- Back-to-back reads from m1 only at addresses 0..15 -> 16 consecutive readdatavalid cycles with in-order data and m1_waitrequest never high.

Source files
------------

// File: rtl/audiomini_mem_pkg.sv
// Shared widths and read-return tag types for the audiomini on-chip RAM arbiter.
package audiomini_mem_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 64;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/audiomini_rd_tag_pipe.sv
// Delay line that carries {valid, requester id} alongside the RAM read latency.
module audiomini_rd_tag_pipe
    import audiomini_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    rd_tag_t stage_reg [LATENCY];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi].valid <= in_valid;
                        stage_reg[gi].id    <= in_id;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stage_reg[LATENCY-1].valid;
    assign out_id    = stage_reg[LATENCY-1].id;

endmodule

// File: rtl/audiomini_onchip_memory_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of the single-port on-chip RAM,
// with read data steered back to the requester that issued the read.
module audiomini_onchip_memory_arbiter
    import audiomini_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_WIDTH-1:0] mem_readdata
);

    logic    req0, req1;
    logic    grant0, grant1, grant_any;
    logic    granted_write, rd_accept;
    logic    ret_valid, ret_id;
    req_id_t grant_id, last_grant_reg;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                grant0 = (last_grant_reg == 1'b1);
                grant1 = (last_grant_reg == 1'b0);
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign grant_any = grant0 | grant1;
    assign grant_id  = grant1;

    assign m0_waitrequest = reset | (req0 & ~grant0);
    assign m1_waitrequest = reset | (req1 & ~grant1);

    // A write wins over a read asserted in the same command.
    assign granted_write = grant1 ? m1_write : (grant0 & m0_write);
    assign rd_accept     = grant_any & ~granted_write;

    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_write      = granted_write;
    assign mem_chipselect = grant_any;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (grant_any) begin
            last_grant_reg <= grant_id;
        end
    end

    audiomini_rd_tag_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst       (reset),
        .in_valid  (rd_accept),
        .in_id     (grant_id),
        .out_valid (ret_valid),
        .out_id    (ret_id)
    );

    assign m0_readdatavalid = ret_valid & (ret_id == 1'b0) & ~reset;
    assign m1_readdatavalid = ret_valid & (ret_id == 1'b1) & ~reset;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_audiomini_onchip_memory_arbiter.sv
// Scoreboard bench: queued commands per master, a rule-level arbitration/RAM model,
// and a monitor matching every readdatavalid against the expected-response queues.
module tb_audiomini_onchip_memory_arbiter;
    import audiomini_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_WIDTH-1:0] m0_address = '0, m1_address = '0, mem_address;
    logic [BE_WIDTH-1:0]   m0_byteenable = '0, m1_byteenable = '0, mem_byteenable;
    logic                  m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DATA_WIDTH-1:0] m0_writedata = '0, m1_writedata = '0, mem_writedata;
    logic                  m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [DATA_WIDTH-1:0] m0_readdata, m1_readdata;
    logic                  mem_chipselect, mem_write, mem_clken;
    logic [DATA_WIDTH-1:0] mem_readdata = '0;

    audiomini_onchip_memory_arbiter #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset(rst),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    typedef struct {
        bit                    wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] data;
        int                    gap;
    } cmd_t;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        int                    cyc;
    } exp_t;

    cmd_t cq0[$], cq1[$];
    exp_t eq0[$], eq1[$];
    cmd_t cur0, cur1;
    bit   busy0 = 0, busy1 = 0, acc0 = 0, acc1 = 0;
    int   vectors = 0, miscompares = 0, cyc = 0;

    // The RAM the arbiter drives: one-cycle registered read, byte-lane writes.
    logic [DATA_WIDTH-1:0] ram [0:(1<<ADDR_WIDTH)-1];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_WIDTH; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference state: what the RAM contents and the round-robin pointer should be.
    logic [DATA_WIDTH-1:0] ref_mem [0:(1<<ADDR_WIDTH)-1];
    bit ref_last = 1;

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [BE_WIDTH-1:0] be);
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_WIDTH; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0b want %0b", name, cyc, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Arbitration model: decide who should be accepted this cycle from the rules.
    bit r0, r1, g0, g1;
    always @(negedge clk) begin
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (rst) begin
            g0 = 0; g1 = 0;
        end else if (r0 && r1) begin
            g0 = ref_last; g1 = !ref_last;
        end else begin
            g0 = r0; g1 = r1;
        end
        chk_bit("m0_waitrequest", m0_waitrequest, rst | (r0 & !g0));
        chk_bit("m1_waitrequest", m1_waitrequest, rst | (r1 & !g1));
        chk_bit("mem_chipselect", mem_chipselect, g0 | g1);
        acc0 = g0;
        acc1 = g1;
        if (rst) begin
            ref_last = 1;
            eq0.delete();
            eq1.delete();
        end else if (g0) begin
            ref_last = 0;
            if (m0_write) ref_mem[m0_address] = merge(ref_mem[m0_address], m0_writedata, m0_byteenable);
            else eq0.push_back('{data: ref_mem[m0_address], addr: m0_address, cyc: cyc + 1});
        end else if (g1) begin
            ref_last = 1;
            if (m1_write) ref_mem[m1_address] = merge(ref_mem[m1_address], m1_writedata, m1_byteenable);
            else eq1.push_back('{data: ref_mem[m1_address], addr: m1_address, cyc: cyc + 1});
        end
    end

    task automatic chk_rsp(input int p, input logic v, input logic [DATA_WIDTH-1:0] d);
        exp_t e;
        bit   have;
        have = (p == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
        if (have) begin
            if (p == 0) e = eq0[0];
            else        e = eq1[0];
        end
        if (v) begin
            vectors++;
            if (!have) begin
                miscompares++;
                $display("FAIL m%0d unexpected readdatavalid cycle %0d data %h", p, cyc, d);
            end else begin
                if (p == 0) void'(eq0.pop_front());
                else        void'(eq1.pop_front());
                if (d !== e.data || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL m%0d readdata addr %h: got %h at cycle %0d, want %h at cycle %0d",
                             p, e.addr, d, cyc, e.data, e.cyc);
                end else begin
                    $display("m%0d read  addr %h data %h cycle %0d", p, e.addr, d, cyc);
                end
            end
        end else if (have && e.cyc <= cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL m%0d missing readdatavalid addr %h: got none by cycle %0d, want %h at cycle %0d",
                     p, e.addr, cyc, e.data, e.cyc);
            if (p == 0) void'(eq0.pop_front());
            else        void'(eq1.pop_front());
        end
    endtask

    // Response monitor, independent of the stimulus side.
    always @(negedge clk) begin
        if (rst) begin
            chk_bit("m0_readdatavalid_in_reset", m0_readdatavalid, 1'b0);
            chk_bit("m1_readdatavalid_in_reset", m1_readdatavalid, 1'b0);
        end else begin
            chk_rsp(0, m0_readdatavalid, m0_readdata);
            chk_rsp(1, m1_readdatavalid, m1_readdata);
        end
    end

    task automatic push_cmd(input int p, input bit wr, input logic [ADDR_WIDTH-1:0] a,
                            input logic [BE_WIDTH-1:0] be, input logic [DATA_WIDTH-1:0] d,
                            input int gap);
        cmd_t c;
        c = '{wr: wr, addr: a, be: be, data: d, gap: gap};
        if (p == 0) cq0.push_back(c);
        else        cq1.push_back(c);
    endtask

    // Each master holds its command until the model sees it accepted.
    task automatic step();
        @(posedge clk);
        #1;
        if (busy0 && acc0) busy0 = 0;
        if (busy1 && acc1) busy1 = 0;
        if (!busy0 && cq0.size() > 0) begin
            if (cq0[0].gap > 0) cq0[0].gap--;
            else begin cur0 = cq0.pop_front(); busy0 = 1; end
        end
        if (!busy1 && cq1.size() > 0) begin
            if (cq1[0].gap > 0) cq1[0].gap--;
            else begin cur1 = cq1.pop_front(); busy1 = 1; end
        end
        m0_read = busy0 & !cur0.wr;  m0_write = busy0 & cur0.wr;
        m0_address = cur0.addr;      m0_byteenable = cur0.be;  m0_writedata = cur0.data;
        m1_read = busy1 & !cur1.wr;  m1_write = busy1 & cur1.wr;
        m1_address = cur1.addr;      m1_byteenable = cur1.be;  m1_writedata = cur1.data;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 || busy0 || busy1 ||
                eq0.size() > 0 || eq1.size() > 0) && n < 5000) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 5000) begin
            miscompares++;
            $display("FAIL %s drain: got %0d cycles without completion, want fewer than 5000", name, n);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) step();
        chk_bit("mem_clken", mem_clken, 1'b1);
        rst = 1'b0;

        // Write then read back on m0.
        push_cmd(0, 1, 13'h0005, 8'hFF, 64'h0123456789ABCDEF, 0);
        push_cmd(0, 0, 13'h0005, 8'hFF, '0, 0);
        drain("m0_write_read");

        // Sustained contention: both read continuously from their own address.
        push_cmd(0, 1, 13'h0010, 8'hFF, 64'h1010101010101010, 0);
        push_cmd(1, 1, 13'h0020, 8'hFF, 64'h2020202020202020, 0);
        drain("prefill");
        for (int i = 0; i < 8; i++) begin
            push_cmd(0, 0, 13'h0010, 8'hFF, '0, 0);
            push_cmd(1, 0, 13'h0020, 8'hFF, '0, 0);
        end
        drain("contention");

        // Partial byte-lane write to the top word.
        push_cmd(1, 1, 13'h1FFF, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 0);
        push_cmd(1, 0, 13'h1FFF, 8'hFF, '0, 0);
        drain("byte_lane");

        // m0 write races m1 read of the same word; m1 was the last winner.
        push_cmd(0, 1, 13'h0100, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 0);
        push_cmd(1, 0, 13'h0100, 8'hFF, '0, 0);
        drain("write_read_race");

        // Reset one cycle after an m1 read is accepted.
        push_cmd(1, 0, 13'h0005, 8'hFF, '0, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!acc1 && n < 50);
        vectors++;
        if (!acc1) begin
            miscompares++;
            $display("FAIL reset_setup: got no m1 acceptance in %0d cycles, want one", n);
        end
        rst = 1'b1;
        push_cmd(0, 0, 13'h0010, 8'hFF, '0, 0);
        push_cmd(1, 0, 13'h0020, 8'hFF, '0, 0);
        repeat (3) step();
        rst = 1'b0;
        drain("reset_mid_read");

        // m1 streams reads over addresses 0..15.
        for (int i = 0; i < 16; i++)
            push_cmd(0, 1, i[ADDR_WIDTH-1:0], 8'hFF, {$urandom, $urandom}, 0);
        drain("stream_prefill");
        for (int i = 0; i < 16; i++)
            push_cmd(1, 0, i[ADDR_WIDTH-1:0], 8'hFF, '0, 0);
        drain("m1_stream");

        // Random mixed traffic over a small address window to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            push_cmd(0, $urandom_range(0, 1) == 1, ADDR_WIDTH'($urandom_range(0, 31)),
                     BE_WIDTH'($urandom), {$urandom, $urandom}, $urandom_range(0, 2));
            push_cmd(1, $urandom_range(0, 1) == 1, ADDR_WIDTH'($urandom_range(0, 31)),
                     BE_WIDTH'($urandom), {$urandom, $urandom}, $urandom_range(0, 2));
        end
        drain("random");

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
